// File: rtl/nbody_pkg.sv
// Shared types and sizing for the n-body timestep datapath.
// The default tag latency is the RAM read plus the getAccl arithmetic chain.
package nbody_pkg;

  localparam int unsigned BODIES      = 512;
  localparam int unsigned IDX_W       = $clog2(BODIES);

  localparam int unsigned MultTime    = 6;
  localparam int unsigned AddTime     = 11;
  localparam int unsigned InvSqrtTime = 24;
  localparam int unsigned RamLat      = 1;
  // dx, dx^2, sum of squares, rsqrt, scale by mass
  localparam int unsigned DEFAULT_PIPE_LAT = RamLat + 2 * AddTime + 2 * MultTime + InvSqrtTime;

  typedef logic [IDX_W-1:0] body_idx_t;

  typedef struct packed {
    logic      valid;
    body_idx_t i;
    logic      first;
    logic      last;
    logic      self;
  } pair_tag_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/force_pair_scheduler_if.sv
// Control, RAM-address and result-tag signals of the all-pairs force scheduler.
// master is the step controller / datapath side, slave is the scheduler.
interface force_pair_scheduler_if #(
  parameter int unsigned IDX_W = nbody_pkg::IDX_W
);

  logic             start;
  logic [IDX_W:0]   num_bodies;
  logic             hold;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] rd_i;
  logic [IDX_W-1:0] rd_j;
  logic             issue_valid;
  logic             out_valid;
  logic [IDX_W-1:0] out_i;
  logic             out_first;
  logic             out_last;
  logic             out_self;

  modport master (
    output start, num_bodies, hold,
    input  busy, done, rd_i, rd_j, issue_valid,
    input  out_valid, out_i, out_first, out_last, out_self
  );

  modport slave (
    input  start, num_bodies, hold,
    output busy, done, rd_i, rd_j, issue_valid,
    output out_valid, out_i, out_first, out_last, out_self
  );

endinterface

// File: rtl/force_pair_scheduler_tag_delay_line.sv
// Fixed-depth shift register of pair tags with asynchronous clear; advances every cycle.
// Usable for aligning any side-band with a fixed-latency datapath.
module tag_delay_line
  import nbody_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_PIPE_LAT
) (
  input  logic      clk,
  input  logic      rst,
  input  pair_tag_t d,
  output pair_tag_t q
);

  pair_tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage[k] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/force_pair_scheduler.sv
// Walks the (i, j) all-pairs space for one timestep, drives the body RAM read
// addresses and labels each acceleration result with its body index and row markers.
module force_pair_scheduler #(
  parameter int unsigned BODIES   = nbody_pkg::BODIES,
  parameter int unsigned IDX_W    = $clog2(BODIES),
  parameter int unsigned PIPE_LAT = nbody_pkg::DEFAULT_PIPE_LAT
) (
  input  logic                   clk,
  input  logic                   rst,
  force_pair_scheduler_if.slave  bus
);

  import nbody_pkg::*;

  localparam int unsigned DW = $clog2(PIPE_LAT + 1);

  state_t           state;
  logic [IDX_W-1:0] i_q, j_q, rd_i_q, rd_j_q;
  logic [IDX_W:0]   nm1_q;
  logic [DW-1:0]    drain_q;
  logic             busy_q, done_q, issue_q;
  pair_tag_t        tag_q, tag_out;
  logic             i_last, j_last;

  // N-1 is kept one bit wider so N == BODIES compares without wrapping
  assign i_last = ({1'b0, i_q} == nm1_q);
  assign j_last = ({1'b0, j_q} == nm1_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      rd_i_q  <= '0;
      rd_j_q  <= '0;
      nm1_q   <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      issue_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      issue_q <= 1'b0;
      tag_q   <= '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            nm1_q  <= bus.num_bodies - (IDX_W + 1)'(1);
            i_q    <= '0;
            j_q    <= '0;
            busy_q <= 1'b1;
            state  <= (bus.num_bodies == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.hold) begin
            rd_i_q      <= i_q;
            rd_j_q      <= j_q;
            issue_q     <= 1'b1;
            tag_q.valid <= 1'b1;
            tag_q.i     <= body_idx_t'(i_q);
            tag_q.first <= (j_q == '0);
            tag_q.last  <= j_last;
            tag_q.self  <= (j_q == i_q);
            if (j_last) begin
              j_q <= '0;
              if (i_last) begin
                state   <= DRAIN;
                drain_q <= '0;
              end else begin
                i_q <= i_q + IDX_W'(1);
              end
            end else begin
              j_q <= j_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_q == DW'(PIPE_LAT - 1)) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          if (!bus.start) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  tag_delay_line #(.DEPTH(PIPE_LAT)) u_tag_delay (
    .clk (clk),
    .rst (rst),
    .d   (tag_q),
    .q   (tag_out)
  );

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_i        = rd_i_q;
  assign bus.rd_j        = rd_j_q;
  assign bus.issue_valid = issue_q;
  assign bus.out_valid   = tag_out.valid;
  assign bus.out_i       = tag_out.i[IDX_W-1:0];
  assign bus.out_first   = tag_out.first;
  assign bus.out_last    = tag_out.last;
  assign bus.out_self    = tag_out.self;

endmodule

// File: tb/tb_force_pair_scheduler.sv
// Directed bench for force_pair_scheduler with BODIES=8, PIPE_LAT=4.
module tb_force_pair_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  force_pair_scheduler_if #(.IDX_W(3)) bus ();

  force_pair_scheduler #(.BODIES(8), .PIPE_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int c;
    int i;
    int j;
    int f;
    int l;
    int s;
  } ev_t;

  ev_t iss_q[$];
  ev_t out_q[$];
  int  done_cyc;

  int exp_i[9]   = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int exp_j[9]   = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int exp_f[9]   = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
  int exp_l[9]   = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int exp_s[9]   = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  int cyc_run[9] = '{2, 3, 4, 5, 6, 7, 8, 9, 10};
  int cyc_hld[9] = '{2, 3, 7, 8, 9, 10, 11, 12, 13};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Starts a pass and logs issue/result events per negedge until done or budget.
  task automatic run_pass(input int n, input int hold_len, input bit poke, input int budget);
    int  hold_applied = 0;
    bit  hold_prev = 1'b0;
    ev_t e;
    iss_q.delete();
    out_q.delete();
    done_cyc = -1;
    @(negedge clk);
    bus.num_bodies = 4'(n);
    bus.start      = 1'b1;
    for (int t = 1; t <= budget; t++) begin
      @(negedge clk);
      if (hold_prev) begin
        chk("hold_issue_valid", bus.issue_valid, 0);
        chk("hold_rd", {bus.rd_i, bus.rd_j}, 6'b000_001);
      end
      if (bus.issue_valid) begin
        e = '{c: t, i: int'(bus.rd_i), j: int'(bus.rd_j), f: 0, l: 0, s: 0};
        iss_q.push_back(e);
      end
      if (bus.out_valid) begin
        e = '{c: t, i: int'(bus.out_i), j: 0, f: int'(bus.out_first),
              l: int'(bus.out_last), s: int'(bus.out_self)};
        out_q.push_back(e);
      end
      if (bus.done) begin
        done_cyc = t;
        break;
      end
      if (hold_len > 0 && iss_q.size() >= 2 && hold_applied < hold_len) begin
        bus.hold = 1'b1;
        hold_applied++;
        hold_prev = 1'b1;
      end else begin
        bus.hold  = 1'b0;
        hold_prev = 1'b0;
      end
      if (poke && t == 4) bus.start = 1'b0;
      if (poke && t == 5) begin
        bus.start      = 1'b1;
        bus.num_bodies = 4'd5;
      end
    end
    bus.hold = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic finish_pass(input string tag);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_done_held"}, bus.done, 1);
      chk({tag, "_busy_low"}, bus.busy, 0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_clear"}, bus.done, 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  task automatic check_n3(input string tag, input int cyc[9], input int done_exp);
    chk({tag, "_n_issue"}, iss_q.size(), 9);
    chk({tag, "_n_out"}, out_q.size(), 9);
    for (int k = 0; k < 9; k++) begin
      if (k < iss_q.size()) begin
        chk({tag, "_issue_cyc"}, iss_q[k].c, cyc[k]);
        chk({tag, "_issue_ij"}, {iss_q[k].i[15:0], iss_q[k].j[15:0]}, {exp_i[k][15:0], exp_j[k][15:0]});
      end
      if (k < out_q.size()) begin
        chk({tag, "_out_cyc"}, out_q[k].c, cyc[k] + 4);
        chk({tag, "_out_i"}, out_q[k].i, exp_i[k]);
        chk({tag, "_out_fls"}, {out_q[k].f[0], out_q[k].l[0], out_q[k].s[0]},
            {exp_f[k][0], exp_l[k][0], exp_s[k][0]});
      end
    end
    chk({tag, "_done_cyc"}, done_cyc, done_exp);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.hold       = 1'b0;
    bus.num_bodies = '0;

    // reset state
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_issue_valid", bus.issue_valid, 0);
    chk("rst_rd", {bus.rd_i, bus.rd_j}, 0);
    chk("rst_out", {bus.out_valid, bus.out_i, bus.out_first, bus.out_last, bus.out_self}, 0);
    @(negedge clk);
    rst = 1'b0;

    // N=3 free-running
    run_pass(3, 0, 1'b0, 50);
    check_n3("n3", cyc_run, 14);
    finish_pass("n3");

    // N=0
    run_pass(0, 0, 1'b0, 20);
    chk("n0_done_cyc", done_cyc, 2);
    chk("n0_n_issue", iss_q.size(), 0);
    chk("n0_n_out", out_q.size(), 0);
    finish_pass("n0");

    // N=3 with 3-cycle hold after the second issue
    run_pass(3, 3, 1'b0, 50);
    check_n3("hold", cyc_hld, 17);
    finish_pass("hold");

    // N=1
    run_pass(1, 0, 1'b0, 20);
    chk("n1_n_issue", iss_q.size(), 1);
    chk("n1_n_out", out_q.size(), 1);
    if (out_q.size() == 1) begin
      chk("n1_out_cyc", out_q[0].c, 6);
      chk("n1_out", {out_q[0].i[7:0], out_q[0].f[0], out_q[0].l[0], out_q[0].s[0]}, {8'd0, 3'b111});
    end
    chk("n1_done_cyc", done_cyc, 6);
    finish_pass("n1");

    // start re-pulsed and num_bodies changed while busy
    run_pass(3, 0, 1'b1, 50);
    check_n3("poke", cyc_run, 14);
    finish_pass("poke");

    // asynchronous reset in the middle of an N=BODIES pass
    @(negedge clk);
    bus.num_bodies = 4'd8;
    bus.start      = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_rst_issue_valid", bus.issue_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_issue", {bus.issue_valid, bus.rd_i, bus.rd_j}, 0);
    chk("mid_rst_out", {bus.out_valid, bus.out_i, bus.out_first, bus.out_last, bus.out_self}, 0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_busy", bus.busy, 0);

    // full N=BODIES pass after reset
    run_pass(8, 0, 1'b0, 200);
    chk("n8_n_issue", iss_q.size(), 64);
    chk("n8_n_out", out_q.size(), 64);
    for (int k = 0; k < 64; k++) begin
      if (k < iss_q.size()) begin
        chk("n8_issue_cyc", iss_q[k].c, 2 + k);
        chk("n8_issue_ij", {iss_q[k].i[15:0], iss_q[k].j[15:0]}, {16'(k / 8), 16'(k % 8)});
      end
      if (k < out_q.size()) begin
        chk("n8_out_cyc", out_q[k].c, 6 + k);
        chk("n8_out_i", out_q[k].i, k / 8);
        chk("n8_out_fls", {out_q[k].f[0], out_q[k].l[0], out_q[k].s[0]},
            {k % 8 == 0, k % 8 == 7, k / 8 == k % 8});
      end
    end
    if (out_q.size() == 64)
      chk("n8_final", {out_q[63].i[7:0], out_q[63].l[0], out_q[63].s[0]}, {8'd7, 2'b11});
    chk("n8_done_cyc", done_cyc, 69);
    finish_pass("n8");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/force_pair_scheduler.md
Name: force_pair_scheduler

Overview:
Sequences the all-pairs acceleration loop for one n-body timestep. Walks the (i, j) index space, drives the read addresses of the position/mass RAMs feeding the pipelined acceleration unit, and carries a fixed-latency tag pipeline. Each result leaving the acceleration unit is labelled with its body index and row markers so the downstream accumulator/velocity-writeback logic needs no counters of its own. The block sits between the top-level step controller (start/done) and the RAM/getAccl datapath.

Parameters:
BODIES, 512, maximum body count; RAM depth.
IDX_W, $clog2(BODIES), body index width.
PIPE_LAT, 59, cycles from issue (address presented) to result valid at the acceleration unit output; covers RAM read latency plus getAccl latency; must be >= 1.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  level request to run one all-pairs pass
num_bodies  in  IDX_W+1  active body count N, 0..BODIES; sampled on accepted start
hold  in  1  downstream back-pressure; freezes issue
busy  out  1  high from accepted start until done asserts
done  out  1  pass complete; level held until start drops
rd_i  out  IDX_W  body-i read address (x, y RAM port a)
rd_j  out  IDX_W  body-j read address (x, y, m RAM port b)
issue_valid  out  1  rd_i/rd_j carry a new pair this cycle
out_valid  out  1  tag valid, aligned with the acceleration unit result
out_i  out  IDX_W  body index the result belongs to
out_first  out  1  result is j==0 for this i (accumulator clear)
out_last  out  1  result is j==N-1 for this i (write back velocity)
out_self  out  1  result is j==i; downstream treats its contribution as zero

Behaviour:
- Reset: rst is asynchronous and active-high; clock clk. All state, counters and tag-pipeline stages clear; every output is 0; state is IDLE.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches N=num_bodies, clears i and j, and sets busy=1. If N==0, go to DONE; otherwise go to ISSUE.
- ISSUE, hold=0: drive rd_i=i, rd_j=j, issue_valid=1, and push tag {1, i, j==0, j==N-1, j==i}.
  - Advance j. When j==N-1: set j=0, i=i+1.
  - The slot with i==N-1 and j==N-1 is the final issue; the next state is DRAIN.
  - Exactly N*N slots are issued, including N self slots.
- ISSUE, hold=1: issue_valid=0; i and j are frozen; rd_i/rd_j hold their values; a bubble (valid=0) is pushed. Hold may last any number of cycles.
- Tag pipeline: PIPE_LAT-stage shift register that advances every cycle regardless of hold.
  - out_* equals the tag pushed PIPE_LAT cycles earlier.
  - For a bubble, out_valid=0 and out_first, out_last and out_self are forced to 0.
- DRAIN: no issue. Count PIPE_LAT cycles after the final issue, then go to DONE. hold is ignored.
- DONE: done=1, busy=0. Stay until start==0, then go to IDLE with done=0. A new pass needs start low for at least one cycle, then high.
- start is ignored while busy. num_bodies changes after acceptance have no effect.
- Counter widths: i and j are IDX_W wide. N==BODIES must not overflow; compare against N-1 held in IDX_W+1 bits.
- N==1: one slot (0,0) with out_first, out_last and out_self all 1.
- Reset mid-pass: the pass is abandoned and in-flight tags are discarded. Downstream must also be reset.

Decomposition:
- Shared package nbody_pkg:
  - body_idx_t (IDX_W bits)
  - pair_tag_t struct {valid, i, first, last, self}
  - state enum
  - BODIES
  - default PIPE_LAT, derived from MultTime, AddTime, InvSqrtTime and RAM latency.
- Sub-module tag_delay_line: a parameterized PIPE_LAT-deep shift register of pair_tag_t with asynchronous clear. Reusable for aligning other datapath side-bands.

Test Plan:
- N=3, PIPE_LAT=4, hold=0 -> issue_valid is high for 9 consecutive cycles with (rd_i, rd_j) = (0,0)(0,1)(0,2)(1,0)...(2,2). out_valid matches 4 cycles later; out_first on j=0, out_last on j=2, out_self on (0,0)(1,1)(2,2). done rises 4 cycles after the last issue.
- N=0 -> no issue_valid and no out_valid ever; done=1 two cycles after start; done stays high until start=0, then IDLE.
- N=3, hold=1 for 3 cycles after the 2nd issue -> rd_i/rd_j hold (0,1), issue_valid=0 for 3 cycles, and the output stream shows a 3-cycle out_valid gap. The sequence is otherwise identical to the first scenario, and done is delayed by 3 cycles.
- N=1 -> a single out_valid with out_first=out_last=out_self=1, out_i=0.
- start pulsed again while busy, and num_bodies changed mid-pass -> the pass is unaffected, with the original N*N slots. done stays asserted until start=0.
- rst asserted mid-ISSUE with N=BODIES -> all outputs go to 0 immediately. A restart after rst release with N=BODIES issues 262144 slots; the final slot is (511,511) with out_last=1, and there is no counter wrap.
